// File: rtl/serial_parity_pkg.sv
// Shared types and constants for the serial parity checker.
// State encoding and parity-sense constants live here so the top and the bench agree.
package serial_parity_pkg;

  typedef enum logic [1:0] {
    RECV_DATA = 2'd0,
    RECV_PAR  = 2'd1,
    HOLD      = 2'd2
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Parity sense selected by the ODD_PARITY parameter (0 even, anything else odd).
  function automatic logic parity_sense(input int odd_parity);
    return (odd_parity != 0) ? PAR_ODD : PAR_EVEN;
  endfunction

endpackage

// File: rtl/serial_parity_checker_parity_accum.sv
// One-bit running XOR accumulator with enable and synchronous clear.
// Clear wins over enable so a resync in the same cycle as a data bit leaves acc at zero.
module parity_accum (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  input  logic d,
  output logic q
);

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else if (clr) begin
      q <= 1'b0;
    end else if (en) begin
      q <= q ^ d;
    end
  end

endmodule

// File: rtl/serial_parity_checker.sv
// Serial-to-word receiver: collects DATA_W data bits LSB first plus one parity bit,
// then holds the word and its parity-error flag on a valid/ready port until taken.
module serial_parity_checker
  import serial_parity_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ODD_PARITY = 0,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sync_clr,
  input  logic              in_valid,
  input  logic              in_bit,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_perr,
  output logic [CNT_W-1:0]  err_count
);

  localparam int BIT_CNT_W = $clog2(DATA_W);
  localparam logic [BIT_CNT_W-1:0] CNT_LAST = BIT_CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] ERR_MAX = {CNT_W{1'b1}};
  localparam logic SENSE = parity_sense(ODD_PARITY);

  state_t               state;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic                 acc;
  logic                 accept;
  logic                 handshake;
  logic                 acc_en;
  logic                 acc_clr;

  // Backpressure depends on state alone, so it never loops through in_valid.
  assign in_ready  = (state != HOLD);
  assign accept    = in_valid && in_ready;
  assign handshake = out_valid && out_ready;

  assign acc_en  = accept && (state == RECV_DATA) && !sync_clr;
  assign acc_clr = sync_clr || handshake;

  parity_accum u_parity_accum (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (acc_en),
    .clr   (acc_clr),
    .d     (in_bit),
    .q     (acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RECV_DATA;
      bit_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_perr  <= 1'b0;
    end else if (sync_clr) begin
      // Resync drops any partial or held frame; out_data is left as-is.
      state     <= RECV_DATA;
      bit_cnt   <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        RECV_DATA: begin
          if (accept) begin
            out_data[bit_cnt] <= in_bit;
            if (bit_cnt == CNT_LAST) begin
              bit_cnt <= '0;
              state   <= RECV_PAR;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        RECV_PAR: begin
          if (accept) begin
            out_perr  <= acc ^ in_bit ^ SENSE;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (handshake) begin
            bit_cnt   <= '0;
            out_valid <= 1'b0;
            state     <= RECV_DATA;
          end
        end
        default: begin
          bit_cnt   <= '0;
          out_valid <= 1'b0;
          state     <= RECV_DATA;
        end
      endcase
    end
  end

  // A delivery coinciding with sync_clr still counts, so this ignores sync_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (handshake && out_perr && (err_count != ERR_MAX)) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_parity_checker.sv
// Self-checking bench: three checker instances (even, odd, 2-bit counter) on shared inputs,
// compared against a frame-level parity model.
module tb_serial_parity_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sync_clr;
  logic       in_valid;
  logic       in_bit;
  logic       out_ready;

  logic       in_ready_e, in_ready_o, in_ready_s;
  logic       out_valid_e, out_valid_o, out_valid_s;
  logic [7:0] out_data_e, out_data_o, out_data_s;
  logic       out_perr_e, out_perr_o, out_perr_s;
  logic [7:0] err_count_e, err_count_o;
  logic [1:0] err_count_s;

  int vectors     = 0;
  int miscompares = 0;
  int err_e = 0, err_o = 0, err_s = 0;

  always #5 clk = ~clk;

  serial_parity_checker #(.DATA_W(8), .ODD_PARITY(0), .CNT_W(8)) dut_even (
    .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(in_ready_e), .out_valid(out_valid_e), .out_ready(out_ready),
    .out_data(out_data_e), .out_perr(out_perr_e), .err_count(err_count_e));

  serial_parity_checker #(.DATA_W(8), .ODD_PARITY(1), .CNT_W(8)) dut_odd (
    .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(in_ready_o), .out_valid(out_valid_o), .out_ready(out_ready),
    .out_data(out_data_o), .out_perr(out_perr_o), .err_count(err_count_o));

  serial_parity_checker #(.DATA_W(8), .ODD_PARITY(0), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(in_ready_s), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_data(out_data_s), .out_perr(out_perr_s), .err_count(err_count_s));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // A frame is in error when the XOR of all DATA_W+1 bits differs from the parity sense.
  function automatic logic exp_perr(input logic [7:0] d, input logic p, input logic odd);
    return ((^d) ^ p) != odd;
  endfunction

  function automatic int sat_add(input int v, input int max);
    return (v < max) ? v + 1 : v;
  endfunction

  task automatic model_deliver(input logic [7:0] d, input logic p);
    if (exp_perr(d, p, 1'b0)) begin
      err_e = sat_add(err_e, 255);
      err_s = sat_add(err_s, 3);
    end
    if (exp_perr(d, p, 1'b1)) err_o = sat_add(err_o, 255);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_cnt_e"}, 32'(err_count_e), 32'(err_e));
    check({tag, "_cnt_o"}, 32'(err_count_o), 32'(err_o));
    check({tag, "_cnt_s"}, 32'(err_count_s), 32'(err_s));
  endtask

  task automatic check_word(input string tag, input logic [7:0] d, input logic p);
    check({tag, "_valid"}, 32'({out_valid_e, out_valid_o, out_valid_s}), 32'h7);
    check({tag, "_data_e"}, 32'(out_data_e), 32'(d));
    check({tag, "_data_o"}, 32'(out_data_o), 32'(d));
    check({tag, "_data_s"}, 32'(out_data_s), 32'(d));
    check({tag, "_perr_e"}, 32'(out_perr_e), 32'(exp_perr(d, p, 1'b0)));
    check({tag, "_perr_o"}, 32'(out_perr_o), 32'(exp_perr(d, p, 1'b1)));
    check({tag, "_perr_s"}, 32'(out_perr_s), 32'(exp_perr(d, p, 1'b0)));
  endtask

  // Tasks start and end just after a falling edge; the DUT samples on the rising edge between.
  task automatic push_bit(input logic b);
    int guard = 0;
    in_valid = 1'b1;
    in_bit   = b;
    while (!in_ready_e && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready_e) begin
      vectors++;
      miscompares++;
      $error("FAIL push_timeout in_ready stuck observed=0 expected=1");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle_gaps(input int gap_pct);
    int n = 0;
    while (n < 8 && $urandom_range(99) < gap_pct) begin
      in_valid = 1'b0;
      in_bit   = 1'($urandom);
      @(negedge clk);
      n++;
    end
  endtask

  task automatic send_bits(input logic [7:0] d, input int nbits, input int gap_pct);
    for (int i = 0; i < nbits; i++) begin
      idle_gaps(gap_pct);
      push_bit(d[i]);
    end
  endtask

  task automatic send_frame(input string tag, input logic [7:0] d, input logic p,
                            input int gap_pct);
    send_bits(d, 8, gap_pct);
    check({tag, "_no_early_valid"}, 32'(out_valid_e), 32'h0);
    idle_gaps(gap_pct);
    push_bit(p);
  endtask

  // Word must be on the port; hold it for 'delay' cycles with junk bits offered, then take it.
  task automatic collect(input string tag, input logic [7:0] d, input logic p, input int delay);
    check_word(tag, d, p);
    for (int k = 0; k < delay; k++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_bit    = 1'($urandom);
      check({tag, "_backpressure"}, 32'({in_ready_e, in_ready_o, in_ready_s}), 32'h0);
      @(negedge clk);
      check({tag, "_hold_data"}, 32'(out_data_e), 32'(d));
      check({tag, "_hold_valid"}, 32'(out_valid_e), 32'h1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    model_deliver(d, p);
    check({tag, "_taken"}, 32'({out_valid_e, out_valid_o, out_valid_s}), 32'h0);
    check({tag, "_ready"}, 32'(in_ready_e), 32'h1);
    check_counts(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'({out_valid_e, out_valid_o, out_valid_s}), 32'h0);
    check({tag, "_data"}, 32'({out_data_e, out_data_o, out_data_s}), 32'h0);
    check({tag, "_perr"}, 32'({out_perr_e, out_perr_o, out_perr_s}), 32'h0);
    check({tag, "_cnt"}, 32'({err_count_e, err_count_o, err_count_s}), 32'h0);
    check({tag, "_in_ready"}, 32'({in_ready_e, in_ready_o, in_ready_s}), 32'h7);
  endtask

  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs(tag);
    err_e = 0; err_o = 0; err_s = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic       p;

    rst_n = 1'b0; sync_clr = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: 0xA5 with even parity, no gaps, consumer always ready
    send_frame("t1", 8'hA5, 1'b0, 0);
    collect("t1", 8'hA5, 1'b0, 0);

    // 2: same word, wrong even parity
    send_frame("t2", 8'hA5, 1'b1, 0);
    collect("t2", 8'hA5, 1'b1, 0);

    // 3: five cycles of backpressure, then 0x3C
    send_frame("t3a", 8'h96, 1'b1, 0);
    collect("t3a", 8'h96, 1'b1, 5);
    send_frame("t3b", 8'h3C, 1'b0, 0);
    collect("t3b", 8'h3C, 1'b0, 0);

    // 4: random frames with 50% input gaps and random consumer stalls
    for (int f = 0; f < 100; f++) begin
      d = 8'($urandom);
      p = 1'($urandom);
      send_frame("t4", d, p, 50);
      collect("t4", d, p, $urandom_range(2));
    end

    // 5a: resync after four data bits, bit offered in the same cycle is dropped
    send_bits(8'hFF, 4, 0);
    sync_clr = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
    @(negedge clk);
    sync_clr = 1'b0; in_valid = 1'b0;
    send_frame("t5a", 8'h0F, 1'b0, 0);
    collect("t5a", 8'h0F, 1'b0, 0);

    // 5b: resync while holding, consumer stalled -> nothing delivered
    send_frame("t5b", 8'h81, 1'b1, 0);
    check_word("t5b", 8'h81, 1'b1);
    sync_clr = 1'b1;
    @(negedge clk);
    sync_clr = 1'b0;
    check("t5b_dropped", 32'({out_valid_e, out_valid_o, out_valid_s}), 32'h0);
    check("t5b_ready", 32'(in_ready_e), 32'h1);
    check_counts("t5b");

    // 5c: resync coinciding with a handshake still counts the delivery
    send_frame("t5c", 8'h01, 1'b0, 0);
    check_word("t5c", 8'h01, 1'b0);
    sync_clr = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    sync_clr = 1'b0; out_ready = 1'b0;
    model_deliver(8'h01, 1'b0);
    check("t5c_dropped", 32'(out_valid_e), 32'h0);
    check_counts("t5c");
    send_frame("t5d", 8'h5A, 1'b0, 0);
    collect("t5d", 8'h5A, 1'b0, 0);

    // 6: fresh counters, five bad frames saturate the 2-bit counter at 3
    async_reset("t6_rst");
    for (int f = 0; f < 5; f++) begin
      d = 8'($urandom);
      p = ~(^d);
      send_frame("t6", d, p, 0);
      collect("t6", d, p, 0);
    end
    check("t6_saturated", 32'(err_count_s), 32'h3);

    // 6b: reset mid-frame loses the partial word; reset during hold clears outputs
    send_bits(8'hC3, 3, 0);
    async_reset("t6_midframe");
    send_frame("t6c", 8'h77, 1'b1, 0);
    check_word("t6c", 8'h77, 1'b1);
    async_reset("t6_hold");
    send_frame("t6d", 8'hE4, 1'b1, 25);
    collect("t6d", 8'hE4, 1'b1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
